// File: rtl/brq_rf_pkg.sv
// Shared types and helpers for the BURAQ multi-port integer register file.
//   dbg_state_e : debug access FSM states
//   REG_ZERO    : hard-wired zero register index
//   REG_SP      : stack pointer index (non-zero reset value)
//   port_slice  : extract port `idx` of a packed per-port vector
package brq_rf_pkg;

    typedef enum logic {
        DBG_IDLE = 1'b0,
        DBG_ACK  = 1'b1
    } dbg_state_e;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 2;

    // port_slice works on vectors of up to SliceVecW bits and slices of up
    // to SliceMaxW bits; callers zero-extend the input and truncate the result.
    localparam int unsigned SliceVecW = 256;
    localparam int unsigned SliceMaxW = 64;

    function automatic logic [SliceMaxW-1:0] port_slice(
        input logic [SliceVecW-1:0] vec,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [SliceMaxW-1:0] res;
        logic [7:0]           pos;
        res = '0;
        for (int unsigned b = 0; b < SliceMaxW; b++) begin
            if ((b < width) && ((idx * width + b) < SliceVecW)) begin
                pos    = 8'(idx * width + b);
                res[b] = vec[pos];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/brq_rf_scoreboard.sv
// Per-register busy scoreboard.
//   brq_clk, brq_rst : clock, asynchronous active-low reset
//   iss_en, iss_addr : mark a destination register busy (issue)
//   we, waddr        : write-back ports; each active port clears its busy bit
//   raddr            : read indices whose busy bits are reported on rbusy
//   rbusy            : registered busy bit per read port, with write-back
//                      bypass override when BypassEn is set
// Register 0 is never busy.
module brq_rf_scoreboard
    import brq_rf_pkg::*;
#(
    parameter int unsigned AddrRegWidth = 5,
    parameter int unsigned NumRead      = 2,
    parameter int unsigned NumWrite     = 1,
    parameter int unsigned BypassEn     = 1
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst,
    input  logic                    iss_en,
    input  logic [AddrRegWidth-1:0] iss_addr,
    input  logic [NumWrite-1:0]     we,
    input  logic [AddrRegWidth-1:0] waddr [NumWrite],
    input  logic [AddrRegWidth-1:0] raddr [NumRead],
    output logic [NumRead-1:0]      rbusy
);

    localparam int unsigned Depth = 2**AddrRegWidth;
    localparam logic [AddrRegWidth-1:0] ZeroIdx = AddrRegWidth'(REG_ZERO);

    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] busy_d;

    // Clears first, then the set: a new producer issued in the same cycle
    // as the old one writes back is still outstanding.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NumWrite; j++) begin
            if (we[j]) begin
                busy_d[waddr[j]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // With bypass, a register being written this cycle is seen as ready
    // unless it is simultaneously re-issued.
    always_comb begin
        rbusy = '0;
        for (int unsigned k = 0; k < NumRead; k++) begin
            rbusy[k] = busy_q[raddr[k]];
            if (BypassEn != 0) begin
                for (int unsigned j = 0; j < NumWrite; j++) begin
                    if (we[j] && (waddr[j] == raddr[k])) begin
                        rbusy[k] = iss_en && (iss_addr == raddr[k]);
                    end
                end
            end
            if (raddr[k] == ZeroIdx) begin
                rbusy[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/brq_regfile_mp.sv
// Multi-port integer register file for the BURAQ core.
//   brq_clk, brq_rst      : clock, asynchronous active-low reset
//   raddr / rdata / rbusy : NumRead combinational read ports + busy bits
//   we / waddr / wdata    : NumWrite write-back ports (higher port wins)
//   iss_en / iss_addr     : scoreboard set on issue
//   dbg_*                 : debug access port (see handshake below)
//   mon_data              : stored contents of register MonReg
//   dbg_state             : current debug FSM state, for observation
// DataWidth must not exceed 64 (limit of port_slice).
//
// Debug handshake: the master raises dbg_req with dbg_we/dbg_addr/dbg_wdata
// stable and holds them until it sees dbg_ack. A request is accepted in a
// cycle where the FSM is idle and no write-back port is active; dbg_ack is
// high for exactly the following cycle, with dbg_rdata valid for reads and
// held afterwards. A request held through the ack cycle is taken as a new
// request, accepted one cycle later at the earliest.
module brq_regfile_mp
    import brq_rf_pkg::*;
#(
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          AddrRegWidth = 5,
    parameter int unsigned          NumRead      = 2,
    parameter int unsigned          NumWrite     = 1,
    parameter int unsigned          BypassEn     = 1,
    parameter logic [DataWidth-1:0] SpResetVal   = 32'h0000_0200,
    parameter int unsigned          MonReg       = 15
) (
    input  logic                             brq_clk,
    input  logic                             brq_rst,
    input  logic [NumRead*AddrRegWidth-1:0]  raddr,
    output logic [NumRead*DataWidth-1:0]     rdata,
    output logic [NumRead-1:0]               rbusy,
    input  logic [NumWrite-1:0]              we,
    input  logic [NumWrite*AddrRegWidth-1:0] waddr,
    input  logic [NumWrite*DataWidth-1:0]    wdata,
    input  logic                             iss_en,
    input  logic [AddrRegWidth-1:0]          iss_addr,
    input  logic                             dbg_req,
    input  logic                             dbg_we,
    input  logic [AddrRegWidth-1:0]          dbg_addr,
    input  logic [DataWidth-1:0]             dbg_wdata,
    output logic                             dbg_ack,
    output logic [DataWidth-1:0]             dbg_rdata,
    output logic [DataWidth-1:0]             mon_data,
    output dbg_state_e                       dbg_state
);

    localparam int unsigned Depth = 2**AddrRegWidth;
    localparam logic [AddrRegWidth-1:0] ZeroIdx = AddrRegWidth'(REG_ZERO);
    localparam logic [AddrRegWidth-1:0] SpIdx   = AddrRegWidth'(REG_SP);
    localparam logic [AddrRegWidth-1:0] MonIdx  = AddrRegWidth'(MonReg);

    logic [DataWidth-1:0]    regs_q [Depth];
    logic [AddrRegWidth-1:0] ra     [NumRead];
    logic [AddrRegWidth-1:0] wa     [NumWrite];
    logic [DataWidth-1:0]    wd     [NumWrite];
    logic [DataWidth-1:0]    rd     [NumRead];

    always_comb begin
        for (int unsigned k = 0; k < NumRead; k++) begin
            ra[k] = AddrRegWidth'(port_slice(SliceVecW'(raddr), k, AddrRegWidth));
        end
        for (int unsigned j = 0; j < NumWrite; j++) begin
            wa[j] = AddrRegWidth'(port_slice(SliceVecW'(waddr), j, AddrRegWidth));
            wd[j] = DataWidth'(port_slice(SliceVecW'(wdata), j, DataWidth));
        end
    end

    // ---------------- debug FSM ----------------
    dbg_state_e state_q;
    dbg_state_e state_d;
    logic       accept;

    // Core write-back always has priority; debug simply waits.
    assign accept = (state_q == DBG_IDLE) && dbg_req && !(|we);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DBG_IDLE: if (accept) state_d = DBG_ACK;
            DBG_ACK:  state_d = DBG_IDLE;
            default:  state_d = DBG_IDLE;
        endcase
    end

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            state_q <= DBG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_ack   = (state_q == DBG_ACK);
    assign dbg_state = state_q;

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            dbg_rdata <= '0;
        end else if (accept && !dbg_we) begin
            dbg_rdata <= regs_q[dbg_addr];
        end
    end

    // ---------------- storage ----------------
    // Ascending port order makes the highest-numbered port win a collision.
    // Debug writes never coincide with core writes (accept requires none).
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            regs_q        <= '{default: '0};
            regs_q[SpIdx] <= SpResetVal;
        end else begin
            for (int unsigned j = 0; j < NumWrite; j++) begin
                if (we[j] && (wa[j] != ZeroIdx)) begin
                    regs_q[wa[j]] <= wd[j];
                end
            end
            if (accept && dbg_we && (dbg_addr != ZeroIdx)) begin
                regs_q[dbg_addr] <= dbg_wdata;
            end
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        for (int unsigned k = 0; k < NumRead; k++) begin
            rd[k] = regs_q[ra[k]];
            if (BypassEn != 0) begin
                for (int unsigned j = 0; j < NumWrite; j++) begin
                    if (we[j] && (wa[j] == ra[k])) begin
                        rd[k] = wd[j];
                    end
                end
            end
            if (ra[k] == ZeroIdx) begin
                rd[k] = '0;
            end
        end
    end

    for (genvar k = 0; k < NumRead; k++) begin : g_rdata
        assign rdata[k*DataWidth +: DataWidth] = rd[k];
    end

    assign mon_data = regs_q[MonIdx];

    brq_rf_scoreboard #(
        .AddrRegWidth (AddrRegWidth),
        .NumRead      (NumRead),
        .NumWrite     (NumWrite),
        .BypassEn     (BypassEn)
    ) u_scoreboard (
        .brq_clk  (brq_clk),
        .brq_rst  (brq_rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .we       (we),
        .waddr    (wa),
        .raddr    (ra),
        .rbusy    (rbusy)
    );

endmodule

// File: tb/tb_brq_regfile_mp.sv
// Self-checking bench for brq_regfile_mp: 2 read ports, 2 write ports,
// bypass enabled.
module tb_brq_regfile_mp;
    import brq_rf_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    // ---------------- clock / reset ----------------
    logic brq_clk = 1'b0;
    logic brq_rst = 1'b0;
    always #5 brq_clk = ~brq_clk;

    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             dbg_req;
    logic             dbg_we;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_wdata;
    logic             dbg_ack;
    logic [DW-1:0]    dbg_rdata;
    logic [DW-1:0]    mon_data;
    dbg_state_e       dbg_state;

    brq_regfile_mp #(
        .DataWidth    (DW),
        .AddrRegWidth (AW),
        .NumRead      (NR),
        .NumWrite     (NW),
        .BypassEn     (1),
        .SpResetVal   (32'h0000_0200),
        .MonReg       (15)
    ) dut (
        .brq_clk   (brq_clk),
        .brq_rst   (brq_rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mon_data  (mon_data),
        .dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_core(input logic [1:0] w, input logic [4:0] wa0, input logic [4:0] wa1,
                              input logic [31:0] wd0, input logic [31:0] wd1,
                              input logic iss, input logic [4:0] ia,
                              input logic [4:0] ra0, input logic [4:0] ra1);
        we       = w;
        waddr    = {wa1, wa0};
        wdata    = {wd1, wd0};
        iss_en   = iss;
        iss_addr = ia;
        raddr    = {ra1, ra0};
    endtask

    task automatic idle_core();
        drive_core(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic dbg_drive(input logic req, input logic wr, input logic [4:0] a, input logic [31:0] d);
        dbg_req   = req;
        dbg_we    = wr;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    task automatic reset_dut();
        brq_rst = 1'b0;
        idle_core();
        dbg_drive(1'b0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge brq_clk);
        brq_rst = 1'b1;
    endtask

    // Waits (bounded) for dbg_ack, sampling on falling edges.
    task automatic wait_ack(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge brq_clk);
            cyc++;
        end while (!dbg_ack && cyc < max_cyc);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic        m_busy [32];

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'h0;
            m_busy[r] = 1'b0;
        end
        m_regs[2] = 32'h0000_0200;
    endtask

    function automatic logic written_now(input logic [4:0] a);
        return (we[0] && waddr[4:0] == a) || (we[1] && waddr[9:5] == a);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we[1] && waddr[9:5] == a) return wdata[63:32];
        if (we[0] && waddr[4:0] == a) return wdata[31:0];
        return m_regs[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (written_now(a)) return iss_en && (iss_addr == a);
        return m_busy[a];
    endfunction

    task automatic model_step();
        logic [31:0] nregs [32];
        for (int r = 0; r < 32; r++) nregs[r] = m_regs[r];
        if (we[0] && waddr[4:0] != 5'd0) nregs[waddr[4:0]] = wdata[31:0];
        if (we[1] && waddr[9:5] != 5'd0) nregs[waddr[9:5]] = wdata[63:32];
        for (int r = 1; r < 32; r++) begin
            if (iss_en && iss_addr == 5'(r)) m_busy[r] = 1'b1;
            else if (written_now(5'(r)))     m_busy[r] = 1'b0;
        end
        for (int r = 0; r < 32; r++) m_regs[r] = nregs[r];
    endtask

    function automatic logic [4:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 5'd15;
        if (sel == 1) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  w;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        logic [31:0] emon;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [DW-1:0] expv;

        tbl[0]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 5'd2,  5'd15, 32'h200,      32'h0,        2'b00, 32'h0};
        tbl[1]  = '{2'b01, 5'd7,  5'd0, 32'hDEADBEEF, 32'h0,    1'b0, 5'd0, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0};
        tbl[2]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 5'd7,  5'd2,  32'hDEADBEEF, 32'h200,      2'b00, 32'h0};
        tbl[3]  = '{2'b01, 5'd0,  5'd0, 32'h1234,     32'h0,    1'b1, 5'd0, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0};
        tbl[4]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
        tbl[5]  = '{2'b11, 5'd5,  5'd5, 32'hAAAA,     32'h5555, 1'b1, 5'd5, 5'd5,  5'd7,  32'h5555,     32'hDEADBEEF, 2'b01, 32'h0};
        tbl[6]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 5'd5,  5'd5,  32'h5555,     32'h5555,     2'b11, 32'h0};
        tbl[7]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b1, 5'd9, 5'd9,  5'd5,  32'h0,        32'h5555,     2'b10, 32'h0};
        tbl[8]  = '{2'b01, 5'd9,  5'd0, 32'h99,       32'h0,    1'b0, 5'd0, 5'd9,  5'd5,  32'h99,       32'h5555,     2'b10, 32'h0};
        tbl[9]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 5'd9,  5'd5,  32'h99,       32'h5555,     2'b10, 32'h0};
        tbl[10] = '{2'b10, 5'd0,  5'd5, 32'h0,        32'h77,   1'b0, 5'd0, 5'd5,  5'd15, 32'h77,       32'h0,        2'b00, 32'h0};
        tbl[11] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 5'd5,  5'd15, 32'h77,       32'h0,        2'b00, 32'h0};
        tbl[12] = '{2'b01, 5'd15, 5'd0, 32'hCAFE0015, 32'h0,    1'b0, 5'd0, 5'd15, 5'd5,  32'hCAFE0015, 32'h77,       2'b00, 32'h0};
        tbl[13] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,    1'b0, 5'd0, 5'd15, 5'd5,  32'hCAFE0015, 32'h77,       2'b00, 32'hCAFE0015};

        reset_dut();
        check("reset dbg_ack", 64'(dbg_ack), 64'd0);
        check("reset dbg_rdata", 64'(dbg_rdata), 64'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge brq_clk);
            drive_core(tbl[i].w, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
                       tbl[i].iss, tbl[i].ia, tbl[i].ra0, tbl[i].ra1);
            #1;
            check($sformatf("vec%0d rdata0", i), 64'(rdata[31:0]),  64'(tbl[i].e0));
            check($sformatf("vec%0d rdata1", i), 64'(rdata[63:32]), 64'(tbl[i].e1));
            check($sformatf("vec%0d rbusy", i),  64'(rbusy),        64'(tbl[i].eb));
            check($sformatf("vec%0d mon", i),    64'(mon_data),     64'(tbl[i].emon));
        end

        // Debug write to x0 is ignored.
        @(negedge brq_clk);
        idle_core();
        dbg_drive(1'b1, 1'b1, 5'd0, 32'h1234);
        wait_ack(10, cyc);
        check("dbg wr x0 ack latency", 64'(cyc), 64'd1);
        dbg_drive(1'b0, 1'b0, 5'd0, 32'h0);
        raddr = {5'd0, 5'd0};
        #1;
        check("dbg wr x0 readback", 64'(rdata[31:0]), 64'd0);

        // Debug write leaves a busy bit alone.
        @(negedge brq_clk);
        drive_core(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
        @(negedge brq_clk);
        idle_core();
        dbg_drive(1'b1, 1'b1, 5'd3, 32'h3333);
        wait_ack(10, cyc);
        check("dbg wr x3 ack latency", 64'(cyc), 64'd1);
        dbg_drive(1'b0, 1'b0, 5'd0, 32'h0);
        raddr = {5'd0, 5'd3};
        #1;
        check("dbg wr x3 data", 64'(rdata[31:0]), 64'h3333);
        check("dbg wr x3 busy kept", 64'(rbusy[0]), 64'd1);

        // Debug read held off by three cycles of core writes.
        @(negedge brq_clk);
        drive_core(2'b01, 5'd6, 5'd0, 32'h60, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        dbg_drive(1'b1, 1'b0, 5'd15, 32'h0);
        exp_q.push_back(32'hCAFE0015);
        for (int c = 0; c < 3; c++) begin
            @(negedge brq_clk);
            check($sformatf("dbg blocked by we c%0d", c), 64'(dbg_ack), 64'd0);
            if (c < 2) drive_core(2'b01, 5'd6, 5'd0, 32'h61 + 32'(c), 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
            else       idle_core();
        end
        wait_ack(10, cyc);
        check("dbg rd after we latency", 64'(cyc), 64'd1);
        expv = exp_q.pop_front();
        check("dbg rd x15 data", 64'(dbg_rdata), 64'(expv));
        dbg_drive(1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge brq_clk);
        check("dbg ack single cycle", 64'(dbg_ack), 64'd0);
        check("dbg rdata held", 64'(dbg_rdata), 64'(expv));

        // Back-to-back requests with dbg_req held high.
        @(negedge brq_clk);
        dbg_drive(1'b1, 1'b0, 5'd2, 32'h0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'hDEADBEEF);
        wait_ack(10, cyc);
        check("b2b first latency", 64'(cyc), 64'd1);
        expv = exp_q.pop_front();
        check("b2b first data", 64'(dbg_rdata), 64'(expv));
        dbg_addr = 5'd7;
        @(negedge brq_clk);
        check("b2b gap cycle", 64'(dbg_ack), 64'd0);
        wait_ack(10, cyc);
        check("b2b second latency", 64'(cyc), 64'd1);
        expv = exp_q.pop_front();
        check("b2b second data", 64'(dbg_rdata), 64'(expv));
        dbg_drive(1'b0, 1'b0, 5'd0, 32'h0);

        // Reset during ACK of a debug write.
        @(negedge brq_clk);
        dbg_drive(1'b1, 1'b1, 5'd4, 32'h4444);
        raddr = {5'd4, 5'd2};
        wait_ack(10, cyc);
        check("rst-in-ack latency", 64'(cyc), 64'd1);
        dbg_drive(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        check("pre-reset x4", 64'(rdata[63:32]), 64'h4444);
        brq_rst = 1'b0;
        #1;
        check("rst dbg_ack drop", 64'(dbg_ack), 64'd0);
        check("rst x2", 64'(rdata[31:0]), 64'h200);
        check("rst x4", 64'(rdata[63:32]), 64'h0);
        check("rst mon", 64'(mon_data), 64'h0);
        check("rst dbg_rdata", 64'(dbg_rdata), 64'h0);
        raddr = {5'd5, 5'd3};
        #1;
        check("rst busy", 64'(rbusy), 64'd0);
        @(negedge brq_clk);
        brq_rst = 1'b1;

        // Randomized core traffic against the model.
        reset_dut();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge brq_clk);
            drive_core(2'($urandom_range(0, 3)), rnd_addr(), rnd_addr(), $urandom(), $urandom(),
                       1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
            #1;
            check($sformatf("rnd%0d rdata0", n), 64'(rdata[31:0]),  64'(model_read(raddr[4:0])));
            check($sformatf("rnd%0d rdata1", n), 64'(rdata[63:32]), 64'(model_read(raddr[9:5])));
            check($sformatf("rnd%0d rbusy0", n), 64'(rbusy[0]),     64'(model_busy(raddr[4:0])));
            check($sformatf("rnd%0d rbusy1", n), 64'(rbusy[1]),     64'(model_busy(raddr[9:5])));
            check($sformatf("rnd%0d mon", n),    64'(mon_data),     64'(m_regs[15]));
            model_step();
        end
        @(negedge brq_clk);
        idle_core();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
